// File: rtl/serial_magnitude_comparator.sv
// serial_magnitude_comparator
// Compares two WIDTH-bit operands DIGIT bits per clock, most significant
// digit first, in either unsigned or two's-complement mode.
// Optional feature macro: SERIAL_CMP_EARLY_EXIT_EN
//   defined   -> the scan stops on the first differing digit
//   undefined -> the scan always walks all NDIG digits (fixed latency)
// Results are identical either way; only the done timing differs.

module serial_magnitude_comparator #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic             less_than,
  output logic             equal_to,
  output logic             greater_than
);

  localparam int NDIG = (DIGIT > 0) ? (WIDTH / DIGIT) : 1;
  localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IDXW-1:0] TOP_IDX = IDXW'(NDIG - 1);

  // Reject parameter sets that cannot be split into whole digits
  generate
    if ((WIDTH < 2) || (DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_params
      $error("serial_magnitude_comparator: WIDTH must be >= 2, DIGIT >= 1 and WIDTH %% DIGIT == 0");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             smode;
  logic [IDXW-1:0]  dig_idx;

  logic             accept;
  logic             last_digit;
  logic             top_digit;
  logic [DIGIT-1:0] a_dig;
  logic [DIGIT-1:0] b_dig;
  logic             dig_lt;
  logic             dig_gt;
  logic             decided;
  logic             scan_end;

  // Digit under test: latched operands are shifted left each step, so the
  // current digit is always the top slice; the sign bit is flipped on the
  // top digit in signed mode so an unsigned compare gives the signed order
  always_comb begin
    accept     = start && ((state == IDLE) || (state == DONE));
    last_digit = (dig_idx == '0);
    top_digit  = (dig_idx == TOP_IDX);
    a_dig      = a_sh[WIDTH-1 -: DIGIT];
    b_dig      = b_sh[WIDTH-1 -: DIGIT];
    if (smode && top_digit) begin
      a_dig[DIGIT-1] = ~a_dig[DIGIT-1];
      b_dig[DIGIT-1] = ~b_dig[DIGIT-1];
    end
    dig_lt     = (a_dig < b_dig);
    dig_gt     = (a_dig > b_dig);
    decided    = less_than || greater_than;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    scan_end   = dig_lt || dig_gt || last_digit;
`else
    scan_end   = last_digit;
`endif
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; DONE lasts one cycle and may chain straight into SCAN
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        if (scan_end) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (accept) begin
          state_nxt = SCAN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Operand capture, digit walk and result capture; the first difference
  // wins and later digits never overwrite it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_sh         <= '0;
      b_sh         <= '0;
      smode        <= 1'b0;
      dig_idx      <= '0;
      less_than    <= 1'b0;
      equal_to     <= 1'b0;
      greater_than <= 1'b0;
    end else if (accept) begin
      a_sh         <= a_in;
      b_sh         <= b_in;
      smode        <= signed_mode;
      dig_idx      <= TOP_IDX;
      less_than    <= 1'b0;
      equal_to     <= 1'b0;
      greater_than <= 1'b0;
    end else if (state == SCAN) begin
      a_sh <= a_sh << DIGIT;
      b_sh <= b_sh << DIGIT;
      if (!last_digit) begin
        dig_idx <= dig_idx - 1'b1;
      end
      if (!decided) begin
        if (dig_lt) begin
          less_than <= 1'b1;
        end else if (dig_gt) begin
          greater_than <= 1'b1;
        end else if (last_digit) begin
          equal_to <= 1'b1;
        end
      end
    end
  end

  assign busy = (state == SCAN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// tb_serial_magnitude_comparator
// Scoreboard bench: every accepted start pushes the model's expected result
// and latency; each done pulse pops and compares. Honours
// SERIAL_CMP_EARLY_EXIT_EN for the expected latency.

module tb_serial_magnitude_comparator;

  localparam int WIDTH = 16;
  localparam int DIGIT = 4;
  localparam int NDIG  = WIDTH / DIGIT;

  typedef struct {
    logic [2:0] res;   // {lt, eq, gt}
    int         lat;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic             less_than;
  logic             equal_to;
  logic             greater_than;

  int   checks = 0;
  int   passed = 0;
  exp_t sb_q[$];

  serial_magnitude_comparator #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk          (clk),
    .reset        (rst_n),
    .start        (start),
    .signed_mode  (signed_mode),
    .a_in         (a_in),
    .b_in         (b_in),
    .busy         (busy),
    .done         (done),
    .less_than    (less_than),
    .equal_to     (equal_to),
    .greater_than (greater_than)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: SV signed/unsigned comparison plus first-differing-digit search
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s);
    exp_t e;
    int   j;
    logic lt;
    logic gt;
    if (s) begin
      lt = ($signed(a) < $signed(b));
      gt = ($signed(a) > $signed(b));
    end else begin
      lt = (a < b);
      gt = (a > b);
    end
    e.res = {lt, !(lt || gt), gt};
    j = 0;
    for (int d = NDIG - 1; d >= 0; d--) begin
      if ((j == 0) && (a[d*DIGIT +: DIGIT] != b[d*DIGIT +: DIGIT])) j = NDIG - d;
    end
    if (j == 0) j = NDIG;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    e.lat = j;
`else
    e.lat = NDIG;
`endif
    return e;
  endfunction

  // Drive one comparison, push its expectation, and wait (bounded) for done.
  // lat is the index of the negedge, counted from the one after E0, where done is seen.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s,
                        input bit interfere, output int lat, output int busy_cyc,
                        output logic [2:0] res);
    sb_q.push_back(model(a, b, s));
    @(negedge clk);
    start = 1'b1; a_in = a; b_in = b; signed_mode = s;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1; busy_cyc = 0; res = 3'bxxx;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (busy) busy_cyc++;
      if (done) begin
        lat = k;
        res = {less_than, equal_to, greater_than};
        break;
      end
      if (interfere && (k == 1)) begin
        start = 1'b1; a_in = ~a; b_in = b ^ 16'h0F0F; signed_mode = ~s;
      end else begin
        start = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; signed_mode = 1'b0; a_in = '0; b_in = '0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy); else passed++;
    checks++; if (done !== 1'b0) $display("[TB] FAIL reset_done: got %b expected 0", done); else passed++;
    checks++;
    if ({less_than, equal_to, greater_than} !== 3'b000)
      $display("[TB] FAIL reset_results: got %b expected 000", {less_than, equal_to, greater_than});
    else passed++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_scenario(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic s, input bit interfere);
    int         lat;
    int         busy_cyc;
    logic [2:0] res;
    exp_t       e;
    run_op(a, b, s, interfere, lat, busy_cyc, res);
    checks++;
    if (lat < 0) begin
      $display("[TB] FAIL %s_timeout: got no done expected done", name);
      if (sb_q.size() > 0) void'(sb_q.pop_front());
      return;
    end else passed++;
    e = sb_q.pop_front();
    checks++; if (res !== e.res) $display("[TB] FAIL %s_result: got %b expected %b", name, res, e.res); else passed++;
    checks++; if (lat !== e.lat) $display("[TB] FAIL %s_latency: got %0d expected %0d", name, lat, e.lat); else passed++;
    checks++; if (busy_cyc !== e.lat) $display("[TB] FAIL %s_busy_cycles: got %0d expected %0d", name, busy_cyc, e.lat); else passed++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL %s_busy_with_done: got %b expected 0", name, busy); else passed++;
    @(negedge clk);
    checks++; if (done !== 1'b0) $display("[TB] FAIL %s_done_pulse: got %b expected 0", name, done); else passed++;
    checks++; if ({less_than, equal_to, greater_than} !== e.res)
      $display("[TB] FAIL %s_result_hold: got %b expected %b", name, {less_than, equal_to, greater_than}, e.res);
    else passed++;
  endtask

  task automatic test_equal();
    test_scenario("equal", 16'h00AB, 16'h00AB, 1'b0, 1'b0);
  endtask

  task automatic test_msb_less();
    test_scenario("msb_less", 16'hA000, 16'hB000, 1'b0, 1'b0);
  endtask

  task automatic test_signed();
    test_scenario("signed_neg", 16'h8000, 16'h0001, 1'b1, 1'b0);
    test_scenario("unsigned_big", 16'h8000, 16'h0001, 1'b0, 1'b0);
    test_scenario("signed_both_neg", 16'hFFF0, 16'hFF00, 1'b1, 1'b0);
  endtask

  task automatic test_ignore_start();
    test_scenario("ignore_start", 16'h1234, 16'h1235, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    for (int i = 0; i < 6; i++) begin
      a = WIDTH'($urandom);
      b = (i == 2) ? a : (a ^ (WIDTH'(1) << $urandom_range(WIDTH - 1, 0)));
      test_scenario("random", a, b, 1'($urandom_range(1, 0)), 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    int         lat;
    int         busy_cyc;
    logic [2:0] res;
    exp_t       e;
    int         k2;
    run_op(16'h0010, 16'h0020, 1'b0, 1'b0, lat, busy_cyc, res);
    e = sb_q.pop_front();
    checks++; if (res !== e.res) $display("[TB] FAIL b2b_first_result: got %b expected %b", res, e.res); else passed++;
    // still in the DONE cycle: request the next comparison
    start = 1'b1; a_in = 16'h7000; b_in = 16'h6FFF; signed_mode = 1'b1;
    sb_q.push_back(model(16'h7000, 16'h6FFF, 1'b1));
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b1) $display("[TB] FAIL b2b_busy: got %b expected 1", busy); else passed++;
    checks++; if ({less_than, equal_to, greater_than} !== 3'b000)
      $display("[TB] FAIL b2b_cleared: got %b expected 000", {less_than, equal_to, greater_than});
    else passed++;
    k2 = -1;
    for (int k = 1; k < 40; k++) begin
      @(negedge clk);
      if (done) begin
        k2 = k;
        break;
      end
    end
    e = sb_q.pop_front();
    checks++; if (k2 !== e.lat) $display("[TB] FAIL b2b_latency: got %0d expected %0d", k2, e.lat); else passed++;
    checks++; if ({less_than, equal_to, greater_than} !== e.res)
      $display("[TB] FAIL b2b_second_result: got %b expected %b", {less_than, equal_to, greater_than}, e.res);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_scan();
    int pulses;
    @(negedge clk);
    start = 1'b1; a_in = 16'h00AB; b_in = 16'h00AB; signed_mode = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL midreset_busy: got %b expected 0", busy); else passed++;
    checks++; if (done !== 1'b0) $display("[TB] FAIL midreset_done: got %b expected 0", done); else passed++;
    checks++; if ({less_than, equal_to, greater_than} !== 3'b000)
      $display("[TB] FAIL midreset_results: got %b expected 000", {less_than, equal_to, greater_than});
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done || busy) pulses++;
    end
    checks++; if (pulses !== 0) $display("[TB] FAIL midreset_no_done: got %0d active cycles expected 0", pulses); else passed++;
  endtask

  initial begin
    test_reset();
    test_equal();
    test_msb_less();
    test_signed();
    test_ignore_start();
    test_back_to_back();
    test_random();
    test_reset_mid_scan();
    checks++; if (sb_q.size() !== 0) $display("[TB] FAIL scoreboard_empty: got %0d entries expected 0", sb_q.size()); else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
